rv64_inst_fetch: RTL and testbench
==================================

Name: rv64_inst_fetch

Overview:
Instruction supplier for the RV64IM virtual hardware machine: drives `riscv_32bits_instruction` into the core instead of the simulator.
- Walks a program counter and reads the byte-wide simulation memory one byte per request.
- Assembles little-endian 32-bit instruction words and hands each to the core over a valid/ready handshake.
- Accepts PC redirects from the core's branch/jump logic.

Parameters:
- XLEN, 64, program counter width.
- MEM_ADDR_W, 28, byte-address width of simulation memory (0x10000000 bytes).
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  load redirect_pc, abort current fetch.
- redirect_pc  in  XLEN  new fetch PC.
- mem_rd_en  out  1  byte read request, single cycle pulse.
- mem_addr  out  MEM_ADDR_W  byte address of the request.
- mem_rvalid  in  1  read data valid, any latency ≥1 cycle after request.
- mem_rdata  in  8  returned byte.
- inst_valid  out  1  instruction word available.
- inst_ready  in  1  core accepts the word.
- riscv_32bits_instruction  out  32  assembled instruction.
- inst_pc  out  XLEN  PC of the presented instruction.

Behaviour:
- Reset values:
  - pc = RESET_PC; state IDLE; byte_idx = 0; drop_pending = 0.
  - mem_rd_en = 0; mem_addr = 0; inst_valid = 0.
  - riscv_32bits_instruction = 0; inst_pc = 0.
- Reset wins over everything. Mid-fetch reset discards the partial word; a response for the old request still arriving after reset is ignored.
- At most one memory request outstanding.
- States:
  - IDLE: next cycle goes to REQ.
  - REQ: pulse mem_rd_en = 1 with mem_addr = pc[MEM_ADDR_W-1:0] + byte_idx (wraps modulo 2^MEM_ADDR_W); go to WAIT.
  - WAIT: on mem_rvalid, write mem_rdata into word bits [8*byte_idx+7 : 8*byte_idx].
    - byte_idx < 3: increment it, go to REQ.
    - byte_idx == 3: go to HOLD with inst_valid = 1 and inst_pc = pc.
  - HOLD: inst_valid and riscv_32bits_instruction are held stable until inst_ready.
    - On inst_valid & inst_ready: pc = pc + 4 (wraps modulo 2^XLEN), byte_idx = 0, inst_valid = 0, go to REQ.
- Latency: the first word is valid 1 + 4×(1 + L) cycles after reset deassertion, where L is memory latency in cycles.
- Redirect (priority just below reset):
  - pc = redirect_pc, byte_idx = 0, inst_valid = 0, go to REQ.
  - In WAIT, if the response has not yet returned, set drop_pending and go to DRAIN instead of REQ.
  - DRAIN: wait for mem_rvalid, discard the byte, clear drop_pending, go to REQ.
  - A redirect in the same cycle as a HOLD handshake: the word counts as accepted, pc takes redirect_pc (not pc + 4).
  - A redirect while in DRAIN updates pc and stays in DRAIN.
- mem_rvalid outside WAIT/DRAIN is ignored.
- No pc[1:0] alignment requirement unless the optional feature is enabled.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Enabled:
  - Adds output fetch_fault (1 bit, reset 0).
  - On entering REQ with byte_idx == 0 and pc[1:0] != 0, no memory request is issued.
  - Instead go to HOLD with inst_valid = 1, riscv_32bits_instruction = 32'h0000_0000, fetch_fault = 1.
  - fetch_fault clears on handshake or redirect.
  - After the handshake, pc does not advance; only a redirect leaves the faulting PC.
- Disabled: no fetch_fault port; misaligned PCs are fetched byte-wise as normal.

Decomposition:
- Shared package rv64_vhm_pkg holds:
  - XLEN and the memory size constant.
  - The state enum: IDLE, REQ, WAIT, HOLD, DRAIN.
  - RESET_PC default and the 32-bit zero/NOP constants.
- One natural sub-module: rv64_inst_assemble, the byte-lane shift register that packs four bytes little-endian.
- The FSM, PC and redirect logic stay in the top.

Test Plan:
- Memory at 0x8000_0000 = 13,05,A0,00, L=1, inst_ready=1 → first word 32'h00A0_0513, inst_pc 0x8000_0000, valid at cycle 9; next request at address 0x8000_0004.
- inst_ready held 0 for 5 cycles → word and inst_pc stable, no mem_rd_en pulses; the first cycle ready=1 completes the handshake, then pc = 0x8000_0004.
- L=3, redirect to 0x8000_0100 while the 2nd byte is in flight → the stale byte is discarded in DRAIN; the next mem_addr is 0x8000_0100 and the delivered word comes only from 0x100..0x103.
- Redirect to 0x8000_0200 in the same cycle as a HOLD handshake → word accepted once, next fetch at 0x8000_0200, not pc + 4.
- rst asserted in WAIT → all outputs zero next cycle, fetch restarts at RESET_PC, the late mem_rvalid is ignored.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x8000_0002 → no mem_rd_en, inst_valid = 1, fetch_fault = 1, word 0; after a redirect to 0x8000_0004, normal fetching resumes.

Source files
------------

// File: rtl/rv64_vhm_pkg.sv
// rtl/rv64_vhm_pkg.sv - shared constants and fetch state encoding for the RV64IM virtual hardware machine
package rv64_vhm_pkg;

  localparam int XLEN       = 64;
  localparam int MEM_ADDR_W = 28;
  localparam logic [XLEN-1:0] MEM_SIZE = 64'h0000_0000_1000_0000;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  localparam logic [31:0] INST_ZERO = 32'h0000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/rv64_inst_fetch_if.sv
// rtl/rv64_inst_fetch_if.sv - memory, redirect and instruction handshake bundle of the fetch unit
// fetch_fault is present only when FETCH_MISALIGN_CHECK_EN is defined.
interface rv64_inst_fetch_if;
  import rv64_vhm_pkg::*;

  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  mem_rd_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic                  mem_rvalid;
  logic [7:0]            mem_rdata;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [31:0]           riscv_32bits_instruction;
  logic [XLEN-1:0]       inst_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  fetch_fault;
`endif

  modport master (
    input  redirect_valid, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
    output mem_rd_en, mem_addr, inst_valid, riscv_32bits_instruction, inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , output fetch_fault
`endif
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
    input  mem_rd_en, mem_addr, inst_valid, riscv_32bits_instruction, inst_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    , input fetch_fault
`endif
  );

endinterface

// File: rtl/rv64_inst_assemble.sv
// rtl/rv64_inst_assemble.sv - byte-lane register packing four fetched bytes into a little-endian word
module rv64_inst_assemble
  import rv64_vhm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [1:0]  byte_idx,
  input  logic [7:0]  wr_byte,
  output logic [31:0] word
);

  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = INST_ZERO;
    end else if (wr_en) begin
      word_d[{byte_idx, 3'b000} +: 8] = wr_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= INST_ZERO;
    end else begin
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/rv64_inst_fetch.sv
// rtl/rv64_inst_fetch.sv - byte-serial instruction fetch FSM with PC redirect for the RV64IM core
// Define FETCH_MISALIGN_CHECK_EN to fault on PCs with pc[1:0] != 0 instead of fetching them.
module rv64_inst_fetch
  import rv64_vhm_pkg::*;
#(
  parameter logic [XLEN-1:0] BOOT_PC = RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  rv64_inst_fetch_if.master   m
);

  fetch_state_e          state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       inst_pc_q, inst_pc_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  drop_pending_q, drop_pending_d;
  logic                  rd_en;
  logic [MEM_ADDR_W-1:0] rd_addr;
  logic                  asm_wr, asm_clr;
  logic [31:0]           asm_word;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                  fault_q, fault_d;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_pc_d      = inst_pc_q;
    byte_idx_d     = byte_idx_q;
    drop_pending_d = drop_pending_q;
    rd_en          = 1'b0;
    rd_addr        = '0;
    asm_wr         = 1'b0;
    asm_clr        = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d        = fault_q;
`endif

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (byte_idx_q == 2'd0 && pc_q[1:0] != 2'b00) begin
          state_d   = S_HOLD;
          inst_pc_d = pc_q;
          asm_clr   = 1'b1;
          fault_d   = 1'b1;
        end else
`endif
        begin
          rd_en   = 1'b1;
          rd_addr = pc_q[MEM_ADDR_W-1:0] + {{(MEM_ADDR_W-2){1'b0}}, byte_idx_q};
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m.mem_rvalid) begin
          asm_wr = 1'b1;
          if (byte_idx_q == 2'd3) begin
            state_d   = S_HOLD;
            inst_pc_d = pc_q;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (m.inst_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          // A faulting PC is re-presented until the core redirects away from it.
          pc_d    = fault_q ? pc_q : pc_q + XLEN'(4);
          fault_d = 1'b0;
`else
          pc_d    = pc_q + XLEN'(4);
`endif
          byte_idx_d = 2'd0;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        if (m.mem_rvalid) begin
          drop_pending_d = 1'b0;
          state_d        = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request issued this cycle or still unanswered must be drained before refetching.
    if (m.redirect_valid) begin
      pc_d       = m.redirect_pc;
      byte_idx_d = 2'd0;
      asm_wr     = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d    = 1'b0;
`endif
      if (rd_en || ((state_q == S_WAIT || state_q == S_DRAIN) && !m.mem_rvalid)) begin
        drop_pending_d = 1'b1;
        state_d        = S_DRAIN;
      end else begin
        drop_pending_d = 1'b0;
        state_d        = S_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= BOOT_PC;
      inst_pc_q      <= '0;
      byte_idx_q     <= 2'd0;
      drop_pending_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_pc_q      <= inst_pc_d;
      byte_idx_q     <= byte_idx_d;
      drop_pending_q <= drop_pending_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q        <= fault_d;
`endif
    end
  end

  rv64_inst_assemble u_assemble (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .wr_en    (asm_wr),
    .byte_idx (byte_idx_q),
    .wr_byte  (m.mem_rdata),
    .word     (asm_word)
  );

  assign m.mem_rd_en                = rd_en;
  assign m.mem_addr                 = rd_addr;
  assign m.inst_valid               = (state_q == S_HOLD);
  assign m.riscv_32bits_instruction = asm_word;
  assign m.inst_pc                  = inst_pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign m.fetch_fault              = fault_q;
`endif

endmodule

// File: tb/tb_rv64_inst_fetch.sv
// tb/tb_rv64_inst_fetch.sv - directed self-checking bench for rv64_inst_fetch
module tb_rv64_inst_fetch;
  import rv64_vhm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv64_inst_fetch_if bus();

  rv64_inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .m   (bus)
  );

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt    = 0;
  logic [7:0]  mem [bit [27:0]];
  logic [27:0] pend_addr = '0;

  function automatic logic [7:0] mem_byte(input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (bus.inst_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
  endtask

  task automatic wait_rd(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.mem_rd_en !== 1'b1 && n < 100);
    check({tag, "_rd_en"}, 64'(bus.mem_rd_en), 64'd1);
  endtask

  // Memory model: one outstanding request, response after lat cycles.
  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_byte(pend_addr);
        end
      end
      if (bus.mem_rd_en === 1'b1) begin
        cnt       = lat;
        pend_addr = bus.mem_addr;
      end
    end
  end

  initial begin
    int n;
    int pulses;
    int unstable;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    mem[28'h000] = 8'h13; mem[28'h001] = 8'h05; mem[28'h002] = 8'hA0; mem[28'h003] = 8'h00;
    mem[28'h004] = 8'h93; mem[28'h005] = 8'h05; mem[28'h006] = 8'h10; mem[28'h007] = 8'h00;
    mem[28'h100] = 8'hB7; mem[28'h101] = 8'h02; mem[28'h102] = 8'h00; mem[28'h103] = 8'h01;
    mem[28'h200] = 8'h33; mem[28'h201] = 8'h05; mem[28'h202] = 8'hB5; mem[28'h203] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("rst_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_valid", 64'(bus.inst_valid), 64'd0);
    check("rst_word", 64'(bus.riscv_32bits_instruction), 64'd0);
    check("rst_inst_pc", bus.inst_pc, 64'd0);

    // First word, L=1, ready high: valid exactly 9 cycles after reset release.
    bus.inst_ready = 1'b1;
    rst            = 1'b0;
    repeat (8) @(negedge clk);
    check("t1_valid_c8", 64'(bus.inst_valid), 64'd0);
    @(negedge clk);
    check("t1_valid_c9", 64'(bus.inst_valid), 64'd1);
    check("t1_word", 64'(bus.riscv_32bits_instruction), 64'h00A0_0513);
    check("t1_inst_pc", bus.inst_pc, 64'h8000_0000);
    @(negedge clk);
    check("t1_next_valid", 64'(bus.inst_valid), 64'd0);
    check("t1_next_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check("t1_next_addr", 64'(bus.mem_addr), 64'h4);

    // Back-pressure: word held stable, no requests while ready is low.
    bus.inst_ready = 1'b0;
    wait_valid("t2");
    check("t2_word", 64'(bus.riscv_32bits_instruction), 64'h0010_0593);
    check("t2_inst_pc", bus.inst_pc, 64'h8000_0004);
    pulses   = 0;
    unstable = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.mem_rd_en !== 1'b0) pulses++;
      if (bus.inst_valid !== 1'b1 || bus.riscv_32bits_instruction !== 32'h0010_0593 ||
          bus.inst_pc !== 64'h8000_0004) unstable++;
    end
    check("t2_stall_pulses", 64'(pulses), 64'd0);
    check("t2_stall_unstable", 64'(unstable), 64'd0);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("t2_accept_valid", 64'(bus.inst_valid), 64'd0);
    check("t2_accept_addr", 64'(bus.mem_addr), 64'h8);

    // L=3, redirect while the second byte is in flight.
    wait_valid("t3_pre");
    lat            = 3;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("t3_addr_c", 64'(bus.mem_addr), 64'hC);
    wait_rd("t3_b1", n);
    check("t3_b1_addr", 64'(bus.mem_addr), 64'hD);
    check("t3_b1_gap", 64'(n), 64'd4);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t3_drain_rd_en", 64'(bus.mem_rd_en), 64'd0);
    wait_rd("t3_redir", n);
    check("t3_redir_addr", 64'(bus.mem_addr), 64'h100);
    check("t3_redir_gap", 64'(n), 64'd2);
    wait_valid("t3");
    check("t3_word", 64'(bus.riscv_32bits_instruction), 64'h0100_02B7);
    check("t3_inst_pc", bus.inst_pc, 64'h8000_0100);

    // Redirect coinciding with the HOLD handshake.
    lat                = 1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    check("t4_valid", 64'(bus.inst_valid), 64'd0);
    check("t4_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check("t4_addr", 64'(bus.mem_addr), 64'h200);
    wait_valid("t4");
    check("t4_word", 64'(bus.riscv_32bits_instruction), 64'h00B5_0533);
    check("t4_inst_pc", bus.inst_pc, 64'h8000_0200);

    // Reset while a byte is outstanding; its late response must be ignored.
    lat            = 3;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    check("t5_addr", 64'(bus.mem_addr), 64'h204);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_rd_en", 64'(bus.mem_rd_en), 64'd0);
    check("t5_rst_addr", 64'(bus.mem_addr), 64'd0);
    check("t5_rst_valid", 64'(bus.inst_valid), 64'd0);
    check("t5_rst_word", 64'(bus.riscv_32bits_instruction), 64'd0);
    check("t5_rst_inst_pc", bus.inst_pc, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_restart_rd_en", 64'(bus.mem_rd_en), 64'd1);
    check("t5_restart_addr", 64'(bus.mem_addr), 64'h0);
    wait_valid("t5");
    check("t5_word", 64'(bus.riscv_32bits_instruction), 64'h00A0_0513);
    check("t5_inst_pc", bus.inst_pc, 64'h8000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    lat                = 1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0002;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t6_no_rd_en", 64'(bus.mem_rd_en), 64'd0);
    @(negedge clk);
    check("t6_valid", 64'(bus.inst_valid), 64'd1);
    check("t6_fault", 64'(bus.fetch_fault), 64'd1);
    check("t6_word", 64'(bus.riscv_32bits_instruction), 64'd0);
    check("t6_inst_pc", bus.inst_pc, 64'h8000_0002);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h8000_0004;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("t6_fault_clr", 64'(bus.fetch_fault), 64'd0);
    check("t6_resume_addr", 64'(bus.mem_addr), 64'h4);
    wait_valid("t6");
    check("t6_resume_word", 64'(bus.riscv_32bits_instruction), 64'h0010_0593);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
